note_sample_player: RTL and testbench
=====================================

// Module: note_sample_player
// PURPOSE
//  Multi-note, parametrised ROM sample player feeding the Audio_Controller
//  DAC FIFO. Plays one of NUM_NOTES trumpet recordings stored back-to-back in
//  one external single-port ROM (a noteC4-style altsyncram, wren tied low).
//  Supports loop or one-shot mode, unsigned/signed ROM data and 2-bit attenuation.
//  Issues exactly one write_audio_out pulse per sample, paced by audio_out_allowed.
// PARAMETERS
//  SAMPLE_W      10     ROM sample width in bits (<=32)
//  ADDR_W        14     offset bits per note slot; slot size 2**ADDR_W words
//  NOTE_W        3      note-select bits; NUM_NOTES = 2**NOTE_W
//  NOTE_LEN      16384  samples played per note, 1..2**ADDR_W; last offset NOTE_LEN-1
//  ROM_LAT       1      ROM read latency in clocks (registered address, unregistered q)
//  UNSIGNED_ROM  1      1: ROM holds offset binary; MSB is inverted to form two's complement
// PORTS
//  CLOCK_50                 in   1                  system clock; all logic on posedge
//  reset                    in   1                  synchronous, active-high
//  play                     in   1                  level; high = sound the note (key held)
//  note_sel                 in   NOTE_W             note index; latched at start and at each loop wrap
//  loop_en                  in   1                  1 = loop note while play is high; 0 = one-shot
//  atten                    in   2                  arithmetic right shift applied to output word
//  rom_addr                 out  NOTE_W+ADDR_W      registered {cur_note, offset}
//  rom_q                    in   SAMPLE_W           ROM data
//  audio_out_allowed        in   1                  DAC FIFO has space
//  left_channel_audio_out   out  32                 current sample word
//  right_channel_audio_out  out  32                 identical to left
//  write_audio_out          out  1                  one-cycle push strobe
//  busy                     out  1                  high in any state except IDLE/HOLD
//  note_done                out  1                  one-cycle pulse when a one-shot note ends
// BEHAVIOUR
//  Reset, any state: state=IDLE. rom_addr, offset, cur_note, sample register, both
//   audio outputs, write_audio_out, busy and note_done all 0.
//  FSM states: IDLE, FETCH, PUSH, HOLD.
//  IDLE: on play=1, latch cur_note<=note_sel, offset<=0, load rom_addr, go to FETCH.
//  FETCH: lasts exactly ROM_LAT+1 cycles after the rom_addr update. On the last edge,
//   capture rom_q into the sample register, update both audio outputs, go to PUSH.
//  PUSH: write_audio_out = (state==PUSH) & audio_out_allowed. This is the only source
//   of write. Stay in PUSH while audio_out_allowed=0. The outputs hold their value.
//   On the edge that completes the push:
//   - play=0: go to IDLE. Stop only at a sample boundary; never drop a fetched sample.
//   - play=1 and offset<NOTE_LEN-1: offset+1, load rom_addr, go to FETCH.
//   - play=1, offset==NOTE_LEN-1, loop_en=1: offset<=0, cur_note<=note_sel, go to FETCH.
//   - play=1, offset==NOTE_LEN-1, loop_en=0: pulse note_done for 1 cycle, go to HOLD.
//  HOLD: no writes. Return to IDLE when play=0, so one key press plays once.
//  play is ignored in FETCH; it is acted on only at the end of PUSH.
//  Sample word: s = UNSIGNED_ROM ? {~q[SAMPLE_W-1], q[SAMPLE_W-2:0]} : q.
//   w = {s, (32-SAMPLE_W)'b0}. out = $signed(w) >>> atten.
//   atten is sampled with rom_q on the capture edge.
//  Offset never exceeds NOTE_LEN-1. rom_addr never leaves the cur_note slot.
//  Latency: play sampled high at edge e0 in IDLE. rom_addr is valid after e0.
//   write_audio_out is high in the cycle after edge e0+ROM_LAT+1, if allowed.
//  Minimum period is ROM_LAT+2 clocks per sample, well below 1042 clocks per 48 kHz frame.
//  Reset mid-operation: abort immediately. No write strobe in the reset cycle or the cycle after.
// TESTING
//  T1 Reset, then play=1 at e0, allowed=1, ROM_LAT=1. Expect rom_addr={note,0} after e0.
//     Expect write high exactly 1 cycle, in the cycle after e2.
//  T2 UNSIGNED_ROM=1, rom_q=10'h200 -> out 32'h0. rom_q=10'h3FF -> 32'h7FC00000.
//     rom_q=10'h000, atten=2 -> 32'hE0000000.
//  T3 allowed low 50 cycles while in PUSH. Expect no write, outputs stable.
//     Allowed rises: one write, next rom_addr = offset+1.
//  T4 NOTE_LEN=4, loop_en=0, play held: exactly 4 writes, addrs 0..3, note_done once, HOLD.
//     Drop play: IDLE. Raise play: restarts at offset 0.
//  T5 NOTE_LEN=4, loop_en=1, note_sel changed 3->5 mid-note: note 3 offsets finish 0..3.
//     Then rom_addr={5,0}. Drop play in FETCH: that sample is pushed, then IDLE.
//  T6 Assert reset during PUSH with allowed=1: write low that cycle.
//     All outputs 0, IDLE, busy=0 next cycle.

Source files
------------

// File: rtl/note_sample_player.sv
// ROM sample player: walks one note slot of an external ROM and pushes each
// sample into the audio DAC FIFO, with loop/one-shot play and output attenuation.
module note_sample_player #(
  parameter int unsigned SAMPLE_W     = 10,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned NOTE_W       = 3,
  parameter int unsigned NOTE_LEN     = 16384,
  parameter int unsigned ROM_LAT      = 1,
  parameter bit          UNSIGNED_ROM = 1'b1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     play,
  input  logic [NOTE_W-1:0]        note_sel,
  input  logic                     loop_en,
  input  logic [1:0]               atten,
  output logic [NOTE_W+ADDR_W-1:0] rom_addr,
  input  logic [SAMPLE_W-1:0]      rom_q,
  input  logic                     audio_out_allowed,
  output logic [31:0]              left_channel_audio_out,
  output logic [31:0]              right_channel_audio_out,
  output logic                     write_audio_out,
  output logic                     busy,
  output logic                     note_done
);

  localparam int unsigned CntW = $clog2(ROM_LAT + 2);
  localparam logic [CntW-1:0]   LastCnt = CntW'(ROM_LAT);
  localparam logic [ADDR_W-1:0] LastOff = ADDR_W'(NOTE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StPush, StHold} state_e;

  state_e              state;
  logic [CntW-1:0]     cnt;
  logic [ADDR_W-1:0]   offset;
  logic [NOTE_W-1:0]   cur_note;
  logic [ADDR_W-1:0]   next_off;
  logic [SAMPLE_W-1:0] s;
  logic signed [31:0]  w;
  logic [31:0]         word;

  // Offset-binary ROM data becomes two's complement by flipping the MSB.
  always_comb begin
    s = rom_q;
    if (UNSIGNED_ROM) s[SAMPLE_W-1] = ~rom_q[SAMPLE_W-1];
    w    = $signed(32'(s) << (32 - SAMPLE_W));
    word = 32'(w >>> atten);
  end

  assign next_off                = offset + 1'b1;
  assign right_channel_audio_out = left_channel_audio_out;
  assign busy                    = (state == StFetch) || (state == StPush);
  // Gated by reset so an aborted push never strobes the FIFO.
  assign write_audio_out         = (state == StPush) && audio_out_allowed && !reset;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state                  <= StIdle;
      cnt                    <= '0;
      offset                 <= '0;
      cur_note               <= '0;
      rom_addr               <= '0;
      left_channel_audio_out <= '0;
      note_done              <= 1'b0;
    end else begin
      note_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (play) begin
            cur_note <= note_sel;
            offset   <= '0;
            rom_addr <= {note_sel, {ADDR_W{1'b0}}};
            cnt      <= '0;
            state    <= StFetch;
          end
        end
        StFetch: begin
          if (cnt == LastCnt) begin
            left_channel_audio_out <= word;
            state                  <= StPush;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StPush: begin
          if (audio_out_allowed) begin
            cnt <= '0;
            if (!play) begin
              state <= StIdle;
            end else if (offset < LastOff) begin
              offset   <= next_off;
              rom_addr <= {cur_note, next_off};
              state    <= StFetch;
            end else if (loop_en) begin
              offset   <= '0;
              cur_note <= note_sel;
              rom_addr <= {note_sel, {ADDR_W{1'b0}}};
              state    <= StFetch;
            end else begin
              note_done <= 1'b1;
              state     <= StHold;
            end
          end
        end
        StHold: begin
          if (!play) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sample_player.sv
// Directed bench for note_sample_player with a registered-address ROM model
// and a 4-sample note slot.
module tb_note_sample_player;

  logic        clk = 1'b0;
  logic        reset, play, loop_en, allowed;
  logic [2:0]  note_sel;
  logic [1:0]  atten;
  logic [16:0] rom_addr;
  logic [16:0] areg = '0;
  logic [9:0]  rom_q;
  logic        force_en;
  logic [9:0]  force_val;
  logic [31:0] left, right;
  logic        wr, busy, note_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM: registered address, unregistered data; content is {note, offset[6:0]}.
  always @(posedge clk) areg <= rom_addr;
  assign rom_q = force_en ? force_val : {areg[16:14], areg[6:0]};

  note_sample_player #(
    .SAMPLE_W(10), .ADDR_W(14), .NOTE_W(3), .NOTE_LEN(4), .ROM_LAT(1), .UNSIGNED_ROM(1'b1)
  ) dut (
    .CLOCK_50               (clk),
    .reset                  (reset),
    .play                   (play),
    .note_sel               (note_sel),
    .loop_en                (loop_en),
    .atten                  (atten),
    .rom_addr               (rom_addr),
    .rom_q                  (rom_q),
    .audio_out_allowed      (allowed),
    .left_channel_audio_out (left),
    .right_channel_audio_out(right),
    .write_audio_out        (wr),
    .busy                   (busy),
    .note_done              (note_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One single-sample play with a forced ROM word.
  task automatic run_one(input string tag, input logic [9:0] q, input logic [1:0] att,
                         input logic [31:0] exp);
    force_en = 1'b1; force_val = q; atten = att; play = 1'b1;
    tick();
    play = 1'b0;
    tick(); tick();
    chk(tag, {32'h0, left}, {32'h0, exp});
    tick();
  endtask

  int nw, nd;

  initial begin
    reset = 1'b1; play = 1'b0; loop_en = 1'b0; allowed = 1'b1;
    note_sel = 3'd0; atten = 2'd0; force_en = 1'b0; force_val = '0;
    tick(); tick();
    chk("rst_addr", rom_addr, 0);
    chk("rst_left", left, 0);
    chk("rst_right", right, 0);
    chk("rst_wr", wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", note_done, 0);

    // T1: latency and single write
    reset = 1'b0; play = 1'b1; note_sel = 3'd2;
    tick();
    chk("t1_addr", rom_addr, 17'h08000);
    chk("t1_busy", busy, 1);
    chk("t1_wr_e0", wr, 0);
    play = 1'b0;
    tick();
    chk("t1_wr_e1", wr, 0);
    tick();
    chk("t1_wr_e2", wr, 1);
    chk("t1_left", left, 32'hC0000000);
    chk("t1_right", right, 32'hC0000000);
    tick();
    chk("t1_wr_e3", wr, 0);
    chk("t1_idle", busy, 0);

    // T2: sample word formatting
    run_one("t2_mid", 10'h200, 2'd0, 32'h00000000);
    run_one("t2_max", 10'h3FF, 2'd0, 32'h7FC00000);
    run_one("t2_min_att2", 10'h000, 2'd2, 32'hE0000000);
    force_en = 1'b0; atten = 2'd0;

    // T3: back-pressure in PUSH
    note_sel = 3'd1; play = 1'b1; allowed = 1'b0;
    tick(); tick(); tick();
    chk("t3_left", left, 32'hA0000000);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t3_stall_wr", wr, 0);
      chk("t3_stall_left", left, 32'hA0000000);
    end
    allowed = 1'b1;
    #1;
    chk("t3_wr_rise", wr, 1);
    tick();
    chk("t3_next_addr", rom_addr, 17'h04001);
    chk("t3_wr_after", wr, 0);
    play = 1'b0;
    tick(); tick();
    chk("t3_wr2", wr, 1);
    tick();
    chk("t3_idle", busy, 0);

    // T4: one-shot note of 4 samples
    loop_en = 1'b0; note_sel = 3'd6; play = 1'b1;
    nw = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (note_done) nd++;
      if (wr) begin
        chk("t4_sample", left, 32'h40000000 + (32'(nw) << 22));
        nw++;
      end
    end
    chk("t4_writes", nw, 4);
    chk("t4_done", nd, 1);
    chk("t4_hold_busy", busy, 0);
    chk("t4_hold_addr", rom_addr, 17'h18003);
    play = 1'b0;
    tick();
    play = 1'b1;
    tick();
    chk("t4_restart", rom_addr, 17'h18000);
    chk("t4_restart_busy", busy, 1);
    play = 1'b0;
    tick(); tick();
    chk("t4_restart_wr", wr, 1);
    tick();
    chk("t4_idle", busy, 0);

    // T5: loop with note change mid-note, stop requested in FETCH
    loop_en = 1'b1; note_sel = 3'd3; play = 1'b1;
    nw = 0;
    for (int i = 0; i < 30 && nw < 4; i++) begin
      tick();
      if (wr) begin
        chk("t5_sample", left, 32'hE0000000 + (32'(nw) << 22));
        nw++;
        if (nw == 1) note_sel = 3'd5;
      end
    end
    chk("t5_writes", nw, 4);
    tick();
    chk("t5_wrap_addr", rom_addr, 17'h14000);
    play = 1'b0;
    tick(); tick();
    chk("t5_last_wr", wr, 1);
    chk("t5_last_left", left, 32'h20000000);
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_wr", wr, 0);

    // T6: reset during PUSH
    loop_en = 1'b0; note_sel = 3'd0; play = 1'b1;
    tick(); tick(); tick();
    chk("t6_push_wr", wr, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_wr", wr, 0);
    tick();
    chk("t6_addr", rom_addr, 0);
    chk("t6_left", left, 0);
    chk("t6_wr", wr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", note_done, 0);
    reset = 1'b0; play = 1'b0;
    tick();
    chk("t6_wr_after", wr, 0);
    chk("t6_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
